// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared hazard-sequencer types: controller state and the per-stage
// enable/flush pair used by the pipeline-register control nets.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic {
        RUN       = 1'b0,
        DMEM_WAIT = 1'b1
    } haz_state_e;

    typedef struct packed {
        logic en;
        logic flush;
    } stage_ctrl_t;

    // Normal advance, frozen register, and bubble-load encodings
    localparam stage_ctrl_t STAGE_ADVANCE = '{en: 1'b1, flush: 1'b0};
    localparam stage_ctrl_t STAGE_HOLD    = '{en: 1'b0, flush: 1'b0};
    localparam stage_ctrl_t STAGE_BUBBLE  = '{en: 1'b1, flush: 1'b1};
    localparam stage_ctrl_t STAGE_RESET   = '{en: 1'b0, flush: 1'b1};

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a
// load in EX has not yet produced.
module hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    output logic              load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_use_rs1 && (ex_rd == id_rs1);
    assign rs2_hit = id_use_rs2 && (ex_rd == id_rs2);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign load_use = ex_memread && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: prioritises data-memory
// waits, redirects, load-use and fetch misses, and counts stalls/redirects.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    input  logic              mem_redirect,
    input  logic              mem_req,
    input  logic              dmem_ready,
    input  logic              imem_ready,
    output logic              if_en,
    output logic              id_en,
    output logic              ex_en,
    output logic              mem_en,
    output logic              wb_en,
    output logic              id_flush,
    output logic              ex_flush,
    output logic              mem_flush,
    output logic              wb_flush,
    output logic              pc_redirect,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    haz_state_e  state;
    haz_state_e  next_state;
    logic        redir_pend;
    logic        next_redir_pend;
    logic        redirect_taken;
    logic        load_use;
    logic        dmem_wait;
    stage_ctrl_t id_ctrl;
    stage_ctrl_t ex_ctrl;
    stage_ctrl_t mem_ctrl;
    stage_ctrl_t wb_ctrl;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_rd      (ex_rd),
        .ex_memread (ex_memread),
        .load_use   (load_use)
    );

    // Once waiting, only dmem_ready releases the freeze
    assign dmem_wait = ((state == DMEM_WAIT) || mem_req) && !dmem_ready;

    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state      = RUN;
        next_redir_pend = redir_pend;
        redirect_taken  = 1'b0;
        pc_redirect     = 1'b0;
        if_en           = 1'b1;
        id_ctrl         = STAGE_ADVANCE;
        ex_ctrl         = STAGE_ADVANCE;
        mem_ctrl        = STAGE_ADVANCE;
        wb_ctrl         = STAGE_ADVANCE;

        if (rst) begin
            if_en    = 1'b0;
            id_ctrl  = STAGE_RESET;
            ex_ctrl  = STAGE_RESET;
            mem_ctrl = STAGE_RESET;
            wb_ctrl  = STAGE_RESET;
        end else if (dmem_wait) begin
            next_state = DMEM_WAIT;
            if_en      = 1'b0;
            id_ctrl    = STAGE_HOLD;
            ex_ctrl    = STAGE_HOLD;
            mem_ctrl   = STAGE_HOLD;
            wb_ctrl    = STAGE_BUBBLE;
        end else if (mem_redirect) begin
            pc_redirect     = 1'b1;
            redirect_taken  = 1'b1;
            id_ctrl         = STAGE_BUBBLE;
            ex_ctrl         = STAGE_BUBBLE;
            mem_ctrl        = STAGE_BUBBLE;
            next_redir_pend = redir_pend || !imem_ready;
        end else if (load_use) begin
            // ID is held, so a pending wrong-path word is not squashed yet
            if_en   = 1'b0;
            id_ctrl = STAGE_HOLD;
            ex_ctrl = STAGE_BUBBLE;
        end else if (!imem_ready) begin
            if_en   = 1'b0;
            id_ctrl = STAGE_BUBBLE;
        end else if (redir_pend) begin
            id_ctrl         = STAGE_BUBBLE;
            next_redir_pend = 1'b0;
        end
    end

    assign id_en     = id_ctrl.en;
    assign ex_en     = ex_ctrl.en;
    assign mem_en    = mem_ctrl.en;
    assign wb_en     = wb_ctrl.en;
    assign id_flush  = id_ctrl.flush;
    assign ex_flush  = ex_ctrl.flush;
    assign mem_flush = mem_ctrl.flush;
    assign wb_flush  = wb_ctrl.flush;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            redir_pend <= 1'b0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            state      <= next_state;
            redir_pend <= next_redir_pend;
            if (!if_en) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (redirect_taken) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
